// File: rtl/step_tick_gen_pkg.sv
// step_tick_gen_pkg: debouncer state enum, board timing defaults and counter width helper
package step_tick_gen_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_e;
  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned DEF_TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned DEF_DEBOUNCE = CLK_HZ / 1000 * DEBOUNCE_MS;
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/step_tick_gen_debounce.sv
// debounce: two-flop synchroniser plus hysteresis FSM turning a bouncing active-low button into a clean pressed level and rise strobe
module debounce
  import step_tick_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic rise
);
  localparam int unsigned CW = cnt_w(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic meta_q, sync_q, level_q, level_d, done;
  always_comb begin
    done = cnt_q == CNT_MAX;
    state_d = state_q;
    cnt_d = '0;
    level_d = level_q;
    case (state_q)
      IDLE: state_d = sync_q ? PRESS_WAIT : IDLE;
      PRESS_WAIT: begin
        state_d = !sync_q ? IDLE : done ? PRESSED : PRESS_WAIT;
        cnt_d = (sync_q && !done) ? cnt_q + CW'(1) : '0;
        level_d = sync_q && done;
      end
      PRESSED: state_d = sync_q ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: begin
        state_d = sync_q ? PRESSED : done ? IDLE : RELEASE_WAIT;
        cnt_d = (!sync_q && !done) ? cnt_q + CW'(1) : '0;
        level_d = sync_q || !done;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      meta_q <= ~btn_n;
      sync_q <= meta_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  assign level = level_q;
  assign rise = level_d && !level_q;
endmodule

// File: rtl/step_tick_gen.sv
// step_tick_gen: single-step / automatic tick enable generator with debounced button, synchronised mode and divided LED square wave
module step_tick_gen
  import step_tick_gen_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic mode,
  output logic tick,
  output logic clk_slow,
  output logic btn_level,
  output logic mode_sync
);
  localparam int unsigned DW = cnt_w(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  logic mode_meta_q, mode_sync_q, mode_sync_d;
  logic tick_q, tick_d, clk_slow_q, clk_slow_d, wrap, rise;
  logic [DW-1:0] div_q, div_d;
  debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .level(btn_level),
    .rise(rise)
  );
  always_comb begin
    mode_sync_d = mode_meta_q;
    wrap = mode_sync_d && mode_sync_q && div_q == DIV_MAX;
    div_d = (!mode_sync_d || !mode_sync_q || wrap) ? '0 : div_q + DW'(1);
    clk_slow_d = clk_slow_q ^ wrap;
    tick_d = wrap || (rise && !mode_sync_d && !tick_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      div_q <= '0;
      tick_q <= 1'b0;
      clk_slow_q <= 1'b0;
    end else begin
      mode_meta_q <= mode;
      mode_sync_q <= mode_sync_d;
      div_q <= div_d;
      tick_q <= tick_d;
      clk_slow_q <= clk_slow_d;
    end
  assign tick = tick_q;
  assign clk_slow = clk_slow_q;
  assign mode_sync = mode_sync_q;
endmodule

// File: tb/tb_step_tick_gen.sv
// tb_step_tick_gen: randomized and directed self-checking bench with a behavioural run-length/age model
module tb_step_tick_gen;
  localparam int T = 10;
  localparam int D = 4;
  localparam int MAXC = 16384;
  logic clk = 1'b0, reset = 1'b1, btn_n = 1'b1, mode = 1'b0;
  logic tick, clk_slow, btn_level, mode_sync;
  logic tick1, slow1, lvl1, ms1;
  int checks = 0, failures = 0;
  int cyc = 0, base = 0;
  logic p_hist[MAXC];
  logic m_hist[MAXC];
  logic m_lvl[2], m_tk[2], m_slow[2], m_ms;
  int m_run[2], m_age[2];
  int tick_log[$], slow_log[$];
  int t1_cnt, lvl_rises, lvl_rise, ms_rise, ms_fall;
  logic o_lvl, o_ms, o_slow;
  step_tick_gen #(.TICK_DIV(T), .DEBOUNCE(D)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .mode(mode),
    .tick(tick), .clk_slow(clk_slow), .btn_level(btn_level), .mode_sync(mode_sync)
  );
  step_tick_gen #(.TICK_DIV(1), .DEBOUNCE(1)) dut1 (
    .clk(clk), .reset(reset), .btn_n(btn_n), .mode(mode),
    .tick(tick1), .clk_slow(slow1), .btn_level(lvl1), .mode_sync(ms1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at edge %0d: got %b want %b", nm, cyc, a, e);
    end
  endtask
  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 1'b0;
      m_tk[c] = 1'b0;
      m_slow[c] = 1'b0;
      m_run[c] = 0;
      m_age[c] = 0;
    end
    m_ms = 1'b0;
    base = cyc;
    o_lvl = 1'b0;
    o_ms = 1'b0;
    o_slow = 1'b0;
  endtask
  task automatic model_edge();
    int n;
    logic s, msn;
    n = cyc - base;
    s = (n >= 2) ? p_hist[cyc-2] : 1'b0;
    msn = (n >= 1) ? m_hist[cyc-1] : 1'b0;
    for (int c = 0; c < 2; c++) begin
      logic rose, auto_t;
      int div;
      rose = 1'b0;
      auto_t = 1'b0;
      div = (c == 0) ? T : 1;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == ((c == 0) ? D : 1) + 1) begin
          m_lvl[c] = s;
          m_run[c] = 0;
          rose = s;
        end
      end else m_run[c] = 0;
      if (msn) begin
        if (m_ms) begin
          m_age[c]++;
          auto_t = (m_age[c] % div) == 0;
        end else m_age[c] = 0;
      end
      if (auto_t) m_slow[c] = !m_slow[c];
      m_tk[c] = auto_t || (rose && !msn && !m_tk[c]);
    end
    m_ms = msn;
  endtask
  task automatic clear();
    tick_log.delete();
    slow_log.delete();
    t1_cnt = 0;
    lvl_rises = 0;
    lvl_rise = -1;
    ms_rise = -1;
    ms_fall = -1;
  endtask
  task automatic step(input logic b_n, input logic m);
    btn_n = b_n;
    mode = m;
    p_hist[cyc] = !b_n;
    m_hist[cyc] = m;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    if (tick) tick_log.push_back(cyc - 1);
    if (tick1) t1_cnt++;
    if (btn_level && !o_lvl) begin
      lvl_rise = cyc - 1;
      lvl_rises++;
    end
    if (mode_sync && !o_ms) ms_rise = cyc - 1;
    if (!mode_sync && o_ms) ms_fall = cyc - 1;
    if (clk_slow != o_slow) slow_log.push_back(cyc - 1);
    o_lvl = btn_level;
    o_ms = mode_sync;
    o_slow = clk_slow;
  endtask
  task automatic do_reset(input int edges, input logic b_n);
    btn_n = b_n;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_tick", tick, 1'b0);
    chk("async_rst_clk_slow", clk_slow, 1'b0);
    chk("async_rst_btn_level", btn_level, 1'b0);
    chk("async_rst_mode_sync", mode_sync, 1'b0);
    repeat (edges) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    reset = 1'b0;
    model_reset();
  endtask
  always @(negedge clk) begin
    chk("tick", tick, m_tk[0]);
    chk("clk_slow", clk_slow, m_slow[0]);
    chk("btn_level", btn_level, m_lvl[0]);
    chk("mode_sync", mode_sync, m_ms);
    chk("tick_div1", tick1, m_tk[1]);
    chk("clk_slow_div1", slow1, m_slow[1]);
    chk("btn_level_db1", lvl1, m_lvl[1]);
    chk("mode_sync_div1", ms1, m_ms);
  end
  initial begin
    int s, r, slow_before, bh, mh;
    logic rb, rm;
    logic bounce[5];
    model_reset();
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("rst_tick", tick, 1'b0);
    chk("rst_clk_slow", clk_slow, 1'b0);
    chk("rst_btn_level", btn_level, 1'b0);
    chk("rst_mode_sync", mode_sync, 1'b0);
    reset = 1'b0;
    model_reset();
    clear();
    s = cyc;
    repeat (20) step(1'b0, 1'b0);
    chk_int("clean_press_level_delay", lvl_rise - s, 6);
    chk_int("clean_press_tick_count", tick_log.size(), 1);
    chk_int("clean_press_tick_at", (tick_log.size() > 0) ? tick_log[0] - s : -1, 6);
    repeat (10) step(1'b1, 1'b0);
    chk_int("release_no_tick", tick_log.size(), 1);
    clear();
    s = cyc;
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (bounce[i]) step(bounce[i], 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk_int("bounce_tick_count", tick_log.size(), 1);
    chk_int("bounce_tick_at", (tick_log.size() > 0) ? tick_log[0] - s : -1, 10);
    repeat (10) step(1'b1, 1'b0);
    clear();
    s = cyc;
    repeat (100) step(1'b1, 1'b1);
    chk_int("mode_sync_latency", ms_rise - s, 1);
    chk_int("auto_tick_count", tick_log.size(), 9);
    chk_int("auto_first_tick", (tick_log.size() > 0) ? tick_log[0] - ms_rise : -1, 10);
    for (int i = 1; i < tick_log.size(); i++) chk_int("auto_tick_spacing", tick_log[i] - tick_log[i-1], 10);
    chk_int("clk_slow_period", (slow_log.size() > 2) ? slow_log[2] - slow_log[0] : -1, 20);
    chk_int("div1_tick_count", t1_cnt, 98);
    clear();
    repeat (6) begin
      repeat (9) step(1'b0, 1'b1);
      repeat (11) step(1'b1, 1'b1);
    end
    chk_int("auto_press_tick_count", tick_log.size(), 12);
    for (int i = 1; i < tick_log.size(); i++) chk_int("auto_press_spacing", tick_log[i] - tick_log[i-1], 10);
    chk_int("auto_press_level_rises", lvl_rises, 6);
    repeat (12) step(1'b1, 1'b0);
    clear();
    repeat (4) step(1'b0, 1'b0);
    do_reset(2, 1'b0);
    r = cyc;
    repeat (15) step(1'b0, 1'b0);
    chk_int("post_reset_tick_count", tick_log.size(), 1);
    chk_int("post_reset_tick_at", (tick_log.size() > 0) ? tick_log[0] - r : -1, 6);
    repeat (10) step(1'b1, 1'b0);
    clear();
    repeat (12) step(1'b1, 1'b1);
    s = cyc;
    repeat (5) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    chk_int("mode_fall_at", ms_fall - s, 6);
    chk_int("mode_fall_tick_count", tick_log.size(), 2);
    chk_int("mode_fall_tick_at", (tick_log.size() > 0) ? tick_log[tick_log.size()-1] - s : -1, 6);
    slow_before = int'(clk_slow);
    repeat (30) step(1'b1, 1'b0);
    chk_int("mode0_no_tick", tick_log.size(), 2);
    chk_int("mode0_clk_slow_held", int'(clk_slow), slow_before);
    clear();
    repeat (25) step(1'b1, 1'b1);
    chk_int("div_cleared_first_tick", (tick_log.size() > 0) ? tick_log[0] - ms_rise : -1, 10);
    rb = 1'b1;
    rm = 1'b1;
    bh = 0;
    mh = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bh == 0) begin
        rb = ~rb;
        bh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
      end
      if (mh == 0) begin
        rm = ~rm;
        mh = $urandom_range(15, 150);
      end
      bh--;
      mh--;
      step(rb, rm);
      if ($urandom_range(0, 799) == 0) do_reset($urandom_range(1, 3), rb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
